// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared opcode/condition encodings and flag-write opcode masks
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111
  } opcode_e;

  typedef enum logic [2:0] {
    COND_NE     = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  // Bit k set means opcode k writes the flag group; upper opcodes write nothing.
  localparam logic [15:0] FLAG_ALL_OPS = 16'h0003;
  localparam logic [15:0] FLAG_Z_OPS   = 16'h0077;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch-condition resolver over Z/V/N
module cond_eval
  import wisc_pkg::*;
(
  input  cond_e cond,
  input  logic  z,
  input  logic  v,
  input  logic  n,
  output logic  taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:     taken = ~z;
      COND_EQ:     taken = z;
      COND_GT:     taken = ~z & ~n;
      COND_LT:     taken = n;
      COND_GTE:    taken = z | ~n;
      COND_LTE:    taken = n | z;
      COND_OVFL:   taken = v;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - EX-stage Z/V/N flag register, bypassed branch resolve, overflow counter
module flag_unit
  import wisc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      alu_result,
  input  logic             alu_ovfl,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken,
  output logic [CNT_W-1:0] ovfl_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic update;
  logic wr_all;
  logic wr_z;
  logic nz;
  logic nv;
  logic nn;
  logic cond_taken;

  // Flush outranks stall: a squashed instruction never reaches the flags.
  assign update = ex_valid & ~stall & ~flush;
  assign wr_all = update & FLAG_ALL_OPS[ex_opcode];
  assign wr_z   = update & FLAG_Z_OPS[ex_opcode];

  // Next-state values double as the same-cycle bypass for the branch in ID.
  assign nz = wr_z   ? (alu_result == 16'h0000) : flag_z;
  assign nn = wr_all ? alu_result[15]           : flag_n;
  assign nv = wr_all ? alu_ovfl                 : flag_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      ovfl_cnt <= '0;
    end else begin
      flag_z <= nz;
      flag_v <= nv;
      flag_n <= nn;
      if (wr_all && alu_ovfl && (ovfl_cnt != CNT_MAX)) begin
        ovfl_cnt <= ovfl_cnt + 1'b1;
      end
    end
  end

  cond_eval u_cond_eval (
    .cond  (cond_e'(br_cond)),
    .z     (nz),
    .v     (nv),
    .n     (nn),
    .taken (cond_taken)
  );

  assign br_taken = br_valid & cond_taken & ~rst;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed and randomized checks of flag_unit against a reference model
module tb_flag_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        br_taken;
  logic [7:0]  ovfl_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit m_z, m_v, m_n;
  int m_cnt;

  flag_unit #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .stall      (stall),
    .flush      (flush),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .br_taken   (br_taken),
    .ovfl_cnt   (ovfl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_true(input int c, input bit z, input bit v, input bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // One cycle: drive at negedge, check bypassed branch, clock, check registers.
  task automatic step(input bit r, input bit v, input int op, input int res, input bit ov,
                      input bit st, input bit fl, input bit bv, input int bc, input string tag);
    bit nz, nv, nn;
    int ncnt;
    @(negedge clk);
    rst = r; ex_valid = v; ex_opcode = op[3:0]; alu_result = res[15:0]; alu_ovfl = ov;
    stall = st; flush = fl; br_valid = bv; br_cond = bc[2:0];
    nz = m_z; nv = m_v; nn = m_n; ncnt = m_cnt;
    if (r) begin
      nz = 0; nv = 0; nn = 0; ncnt = 0;
    end else if (v && !st && !fl) begin
      if (op == 0 || op == 1) begin
        nz = (res[15:0] == 0); nn = res[15]; nv = ov;
        if (ov && ncnt < 255) ncnt++;
      end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
        nz = (res[15:0] == 0);
      end
    end
    #1;
    if (r) chk({tag, ":br_taken"}, br_taken, 0);
    else   chk({tag, ":br_taken"}, br_taken, bv && cond_true(bc, nz, nv, nn));
    @(posedge clk);
    #1;
    m_z = nz; m_v = nv; m_n = nn; m_cnt = ncnt;
    chk({tag, ":flag_z"}, flag_z, m_z);
    chk({tag, ":flag_v"}, flag_v, m_v);
    chk({tag, ":flag_n"}, flag_n, m_n);
    chk({tag, ":ovfl_cnt"}, ovfl_cnt, m_cnt);
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_opcode = 0; alu_result = 0; alu_ovfl = 0;
    stall = 0; flush = 0; br_valid = 0; br_cond = 0;
    m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;

    step(1, 0, 0, 0, 0, 0, 0, 1, 7, "reset");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, "idle_eq");
    chk("idle_z_zero", flag_z, 0);
    step(0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, "add_zero_eq");
    chk("add_zero_z", flag_z, 1);
    step(0, 1, 1, 16'h8000, 1, 0, 0, 1, 6, "sub_ovfl_branch");
    step(0, 1, 1, 16'h8000, 1, 0, 0, 1, 2, "sub_gt_branch");
    chk("sub_n", flag_n, 1);
    step(0, 1, 0, 16'h7FFF, 1, 0, 0, 1, 3, "add_sat_pos");
    chk("add_sat_n", flag_n, 0);
    step(0, 1, 0, 16'h9000, 1, 0, 0, 0, 0, "preset_nv");
    step(0, 1, 2, 16'h0000, 0, 0, 0, 1, 1, "xor_zero");
    chk("xor_keeps_v", flag_v, 1);
    step(0, 1, 7, 16'h0000, 0, 0, 0, 1, 5, "paddsb_nochange");
    step(0, 1, 3, 16'h1234, 1, 0, 0, 1, 6, "red_nochange");
    step(0, 1, 9, 16'h0000, 1, 0, 0, 1, 1, "op9_nochange");
    step(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, "stall1");
    step(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, "stall2");
    step(0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, "stall3");
    step(0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, "stall_release");
    step(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, "post_release");
    step(0, 1, 0, 16'h1111, 1, 1, 1, 1, 1, "flush_stall");
    step(0, 1, 1, 16'h8000, 1, 0, 1, 1, 0, "flush_only");
    step(0, 0, 0, 16'h8000, 1, 0, 0, 1, 3, "invalid_op");

    for (int i = 0; i < 260; i++) step(0, 1, 0, 16'h7FFF, 1, 0, 0, 1, 6, "sat_run");
    chk("sat_cnt_max", ovfl_cnt, 8'hFF);
    step(0, 1, 1, 16'h8000, 1, 1, 0, 1, 7, "pre_rst_stall");
    step(1, 1, 1, 16'h8000, 1, 1, 0, 1, 7, "rst_mid_stall");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, "after_rst");

    for (int i = 0; i < 600; i++) begin
      int res;
      case ($urandom_range(0, 3))
        0: res = 16'h0000;
        1: res = 16'h8000;
        2: res = 16'h7FFF;
        default: res = int'($urandom_range(0, 16'hFFFF));
      endcase
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8, int'($urandom_range(0, 15)), res,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
